// File: rtl/gate_truth_checker.sv
// Checks sampled (a, b, y) triples from a 2-input gate against a truth table,
// tracking input coverage, mismatch count and the first failing sample.
module gate_truth_checker #(
  parameter logic [3:0] TRUTH   = 4'b1001,
  parameter int         CNT_W   = 8,
  parameter int         TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       covered,
  output logic             fail_valid,
  output logic [1:0]       fail_idx,
  output logic             fail_y
);

  localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_idx_q, fail_idx_d;
  logic             fail_y_q, fail_y_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic [1:0]       idx;
  logic             mism;
  logic [3:0]       cov_now;
  logic [CNT_W-1:0] err_now;

  always_comb begin
    idx     = {a, b};
    mism    = (y != TRUTH[idx]);
    cov_now = in_valid ? (cov_q | (4'b0001 << idx)) : cov_q;
    // Saturating increment: the counter sticks at all-ones.
    if (in_valid && mism && (err_q != {CNT_W{1'b1}}))
      err_now = err_q + CNT_W'(1);
    else
      err_now = err_q;

    state_d      = state_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    cov_d        = cov_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    fail_y_d     = fail_y_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          cyc_d        = '0;
          err_d        = '0;
          cov_d        = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = 2'b00;
          fail_y_d     = 1'b0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (in_valid) begin
          cov_d = cov_now;
          err_d = err_now;
          if (mism && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = idx;
            fail_y_d     = y;
          end
        end
        // Completion on the last allowed cycle takes priority over timeout.
        if (cov_now == 4'b1111) begin
          state_d   = DONE;
          pass_d    = (err_now == '0);
          timeout_d = 1'b0;
        end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      err_q        <= '0;
      cov_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= 2'b00;
      fail_y_q     <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      err_q        <= err_d;
      cov_q        <= cov_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      fail_y_q     <= fail_y_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign err_count  = err_q;
  assign covered    = cov_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign fail_y     = fail_y_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: expected run results are queued per checker instance and
// compared by monitors when done rises; a few mid-run states are checked directly.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, a = 1'b0, b = 1'b0, y = 1'b0;
  logic start_a = 1'b0, start_c = 1'b0, start_n = 1'b0;

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] cyc;
    logic       pass;
    logic       tmo;
    logic [7:0] err;
    logic [3:0] cov;
    logic       fv;
    logic [1:0] fi;
    logic       fy;
  } res_t;

  res_t q_a[$], q_c[$], q_n[$];

  // dut_a: default XNOR; dut_c: 2-bit error counter; dut_n: AND truth table
  logic bsy_a, dn_a, ps_a, to_a, fv_a, fy_a; logic [7:0] ec_a; logic [3:0] cv_a; logic [1:0] fi_a;
  logic bsy_c, dn_c, ps_c, to_c, fv_c, fy_c; logic [1:0] ec_c; logic [3:0] cv_c; logic [1:0] fi_c;
  logic bsy_n, dn_n, ps_n, to_n, fv_n, fy_n; logic [7:0] ec_n; logic [3:0] cv_n; logic [1:0] fi_n;

  gate_truth_checker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .a(a), .b(b), .y(y),
    .busy(bsy_a), .done(dn_a), .pass(ps_a), .timeout(to_a), .err_count(ec_a),
    .covered(cv_a), .fail_valid(fv_a), .fail_idx(fi_a), .fail_y(fy_a));

  gate_truth_checker #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .a(a), .b(b), .y(y),
    .busy(bsy_c), .done(dn_c), .pass(ps_c), .timeout(to_c), .err_count(ec_c),
    .covered(cv_c), .fail_valid(fv_c), .fail_idx(fi_c), .fail_y(fy_c));

  gate_truth_checker #(.TRUTH(4'b1000)) dut_n (
    .clk(clk), .rst(rst), .start(start_n), .in_valid(in_valid), .a(a), .b(b), .y(y),
    .busy(bsy_n), .done(dn_n), .pass(ps_n), .timeout(to_n), .err_count(ec_n),
    .covered(cv_n), .fail_valid(fv_n), .fail_idx(fi_n), .fail_y(fy_n));

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_res(input string d, input res_t act, input res_t exp);
    chk({d, ".run_cycles"}, act.cyc, exp.cyc);
    chk({d, ".pass"}, act.pass, exp.pass);
    chk({d, ".timeout"}, act.tmo, exp.tmo);
    chk({d, ".err_count"}, act.err, exp.err);
    chk({d, ".covered"}, act.cov, exp.cov);
    chk({d, ".fail_valid"}, act.fv, exp.fv);
    chk({d, ".fail_idx"}, act.fi, exp.fi);
    chk({d, ".fail_y"}, act.fy, exp.fy);
    $display("%s run done: cyc=%0d pass=%0b tmo=%0b err=%0d cov=%b fail=%0b/%b/%0b",
             d, act.cyc, act.pass, act.tmo, act.err, act.cov, act.fv, act.fi, act.fy);
  endtask

  function automatic res_t mk(int cyc, bit p, bit t, int e, logic [3:0] cv, bit fv,
                              logic [1:0] fi, bit fy);
    res_t r;
    r.cyc = 8'(cyc); r.pass = p; r.tmo = t; r.err = 8'(e);
    r.cov = cv; r.fv = fv; r.fi = fi; r.fy = fy;
    return r;
  endfunction

  // Monitors: count RUN cycles, compare against the queue head when done rises.
  int   cnt_a = 0, cnt_c = 0, cnt_n = 0;
  logic pb_a = 0, pd_a = 0, pb_c = 0, pd_c = 0, pb_n = 0, pd_n = 0;

  always @(negedge clk) begin
    if (bsy_a) cnt_a = pb_a ? cnt_a + 1 : 1;
    if (dn_a && !pd_a) begin
      if (q_a.size() == 0) chk("dut_a.unexpected_done", 1, 0);
      else cmp_res("dut_a", {8'(cnt_a), ps_a, to_a, ec_a, cv_a, fv_a, fi_a, fy_a}, q_a.pop_front());
    end
    pb_a = bsy_a; pd_a = dn_a;
  end

  always @(negedge clk) begin
    if (bsy_c) cnt_c = pb_c ? cnt_c + 1 : 1;
    if (dn_c && !pd_c) begin
      if (q_c.size() == 0) chk("dut_c.unexpected_done", 1, 0);
      else cmp_res("dut_c", {8'(cnt_c), ps_c, to_c, {6'd0, ec_c}, cv_c, fv_c, fi_c, fy_c}, q_c.pop_front());
    end
    pb_c = bsy_c; pd_c = dn_c;
  end

  always @(negedge clk) begin
    if (bsy_n) cnt_n = pb_n ? cnt_n + 1 : 1;
    if (dn_n && !pd_n) begin
      if (q_n.size() == 0) chk("dut_n.unexpected_done", 1, 0);
      else cmp_res("dut_n", {8'(cnt_n), ps_n, to_n, ec_n, cv_n, fv_n, fi_n, fy_n}, q_n.pop_front());
    end
    pb_n = bsy_n; pd_n = dn_n;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic samp(input logic [2:0] v);
    {a, b, y} = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int sel);
    case (sel)
      0: start_a = 1'b1;
      1: start_c = 1'b1;
      default: start_n = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_c = 1'b0; start_n = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string name);
    int k;
    logic d;
    for (k = 0; k < 200; k++) begin
      d = (sel == 0) ? dn_a : (sel == 1) ? dn_c : dn_n;
      if (d) break;
      @(posedge clk); #1;
    end
    if (k == 200) chk({name, ".done_wait_expired"}, 1, 0);
    idle(2);
  endtask

  task automatic xnor_seq(input logic y01);
    samp(3'b001); samp({2'b01, y01}); samp(3'b100); samp(3'b111);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    chk("reset.busy", bsy_a, 0);
    chk("reset.done", dn_a, 0);
    chk("reset.err_count", ec_a, 0);
    chk("reset.covered", cv_a, 0);
    chk("reset.fail_valid", fv_a, 0);

    // in_valid in IDLE has no effect
    samp(3'b000);
    chk("idle_ignore.covered", cv_a, 0);
    chk("idle_ignore.busy", bsy_a, 0);

    // Full clean XNOR coverage
    q_a.push_back(mk(4, 1, 0, 0, 4'hF, 0, 2'b00, 0));
    do_start(0); xnor_seq(1'b0); wait_done(0, "t1");

    // DONE ignores in_valid
    samp(3'b000);
    chk("done_hold.err_count", ec_a, 0);
    chk("done_hold.done", dn_a, 1);

    // Back-to-back run with one mismatch at index 01
    q_a.push_back(mk(4, 0, 0, 1, 4'hF, 1, 2'b01, 1));
    do_start(0); xnor_seq(1'b1); wait_done(0, "t2");

    // Partial coverage -> timeout after 64 RUN cycles
    q_a.push_back(mk(64, 0, 1, 0, 4'b1001, 0, 2'b00, 0));
    do_start(0); samp(3'b001); samp(3'b111); wait_done(0, "t3");

    // Completing sample on the final allowed cycle
    q_a.push_back(mk(64, 1, 0, 0, 4'hF, 0, 2'b00, 0));
    do_start(0); samp(3'b001); samp(3'b010); samp(3'b100);
    idle(60);
    chk("t4.busy_before_last", bsy_a, 1);
    samp(3'b111); wait_done(0, "t4");

    // AND table: XNOR stimulus mismatches only at index 00; rerun from DONE
    q_n.push_back(mk(4, 0, 0, 1, 4'hF, 1, 2'b00, 1));
    q_n.push_back(mk(4, 0, 0, 1, 4'hF, 1, 2'b00, 1));
    do_start(2); xnor_seq(1'b0); wait_done(2, "t6a");
    do_start(2); xnor_seq(1'b0); wait_done(2, "t6b");

    // 2-bit counter saturation
    q_c.push_back(mk(8, 0, 0, 3, 4'hF, 1, 2'b00, 0));
    do_start(1);
    samp(3'b000); samp(3'b000); samp(3'b000);
    chk("t5.err_at_3", ec_c, 3);
    samp(3'b000); samp(3'b000);
    chk("t5.err_saturated", ec_c, 3);
    chk("t5.covered_partial", cv_c, 1);
    samp(3'b010); samp(3'b100); samp(3'b111);
    wait_done(1, "t5");

    // Reset mid-run discards everything
    do_start(1); samp(3'b000);
    chk("t5r.err_before_rst", ec_c, 1);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("t5r.busy", bsy_c, 0);
    chk("t5r.done", dn_c, 0);
    chk("t5r.err_count", ec_c, 0);
    chk("t5r.covered", cv_c, 0);
    chk("t5r.fail_valid", fv_c, 0);
    chk("t5r.fail_idx", fi_c, 0);
    chk("t5r.fail_y", fy_c, 0);
    chk("t5r.pass_tmo", {ps_c, to_c}, 0);
    samp(3'b010); samp(3'b000);
    chk("t5r.idle_covered", cv_c, 0);
    chk("t5r.idle_err", ec_c, 0);
    chk("t5r.idle_busy", bsy_c, 0);

    idle(3);
    chk("scoreboard.pending", q_a.size() + q_c.size() + q_n.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
